sauria_cfg_axil_master: RTL and testbench
=========================================

// Module: sauria_cfg_axil_master
// PURPOSE
//  AXI4-Lite initiator that drives the SAURIA configuration slave port from a simple command stream.
//  Used by a host-side sequencer or testbench to program config registers and poll status.
//  One transaction in flight; each command yields exactly one response.
//  A timeout detects a hung slave.
// PARAMETERS
//  ADDR_W       32    AXI4-Lite address width
//  DATA_W       32    AXI4-Lite data width (multiple of 8); STRB_W = DATA_W/8
//  TIMEOUT_CYC  1024  max cycles waiting for B/R after address/data handoff; 0 = disabled
// PORTS
//  i_clk         in   1       clock
//  i_rstn        in   1       asynchronous reset, active-low
//  i_cmd_valid   in   1       command valid
//  o_cmd_ready   out  1       command accepted when valid&ready
//  i_cmd_we      in   1       1 = write, 0 = read
//  i_cmd_addr    in   ADDR_W  register byte address
//  i_cmd_wdata   in   DATA_W  write data (ignored on read)
//  i_cmd_wstrb   in   STRB_W  write byte strobes (ignored on read)
//  o_rsp_valid   out  1       response valid
//  i_rsp_ready   in   1       response consumed when valid&ready
//  o_rsp_rdata   out  DATA_W  read data; 0 for writes
//  o_rsp_resp    out  2       BRESP/RRESP; 2'b10 on timeout
//  o_rsp_timeout out  1       response generated by timeout
//  o_busy        out  1       state != IDLE
//  o_aw{valid,addr} / i_awready, o_w{valid,data,strb} / i_wready, i_b{valid,resp} / o_bready,
//  o_ar{valid,addr} / i_arready, i_r{valid,data,resp} / o_rready: AXI4-Lite master channels
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (valids, readies, addr/data/strb regs, rsp fields, o_busy), timeout ctr 0.
//  o_cmd_ready = (state==IDLE). On accept, cmd fields are registered; AXI outputs driven only from regs.
//  FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RSP, HUNG.
//   IDLE: on accept go to WADDR if we=1, else RADDR.
//   WADDR: awvalid and wvalid assert together.
//    Each drops independently on its own handshake.
//    AW and W may complete in either order or in the same cycle.
//    Leave for WRESP when both are done.
//   WRESP: bready=1; on bvalid capture bresp, rdata=0, go to RSP.
//   RADDR: arvalid=1 until arready; then RDATA.
//   RDATA: rready=1; on rvalid capture rdata/rresp, go to RSP.
//   RSP: rsp_valid=1, fields stable until rsp_ready; then IDLE (or HUNG if timeout flag set).
//   HUNG: sticky; cmd_ready=0, all AXI valids/readies 0; exit only by reset.
//  AXI rules:
//   - valid never depends on ready; once asserted, valid and payload are held until handshake.
//   - bready/rready are asserted only in WRESP/RDATA.
//  Timeout: counter clears on entry to WRESP/RDATA and increments each cycle there.
//   At count==TIMEOUT_CYC-1 without bvalid/rvalid: go to RSP with resp=2'b10, timeout=1, rdata=0.
//   After consumption go to HUNG; a late B/R is never acknowledged.
//   If bvalid/rvalid arrive in the same cycle as expiry, the normal response wins (no timeout).
//   AW/W/AR phases have no timeout.
//  Latency, zero-wait slave: accept at cycle N; AW/W/AR valid at N+1; bready/rready at N+2; rsp_valid at N+3.
//   Back-to-back: next cmd accepted the cycle after rsp handshake.
//   Throughput: one transaction per 4 cycles minimum.
//  Reset mid-transaction: all valids drop asynchronously, state IDLE; the in-flight command is lost.
// TESTING
//  1. Write 0x0000_0010 data 0xDEADBEEF strb 0xF, slave ready/bvalid immediate:
//     AW/W at N+1; rsp_valid at N+3, resp=00, rdata=0.
//  2. Write with wready at cycle 1, awready at cycle 3 after valid:
//     wvalid drops after cycle 1, awvalid held 3 cycles with stable addr; single B; one rsp.
//  3. Read 0x0000_0004, slave rvalid after 5 cycles with rdata=0x1234_5678 rresp=10:
//     rsp rdata=0x12345678, resp=10, timeout=0.
//  4. TIMEOUT_CYC=8, read, slave never asserts rvalid:
//     rsp_valid 8 cycles into RDATA, resp=10, timeout=1.
//     After rsp_ready: cmd_ready stays 0 (HUNG) until reset.
//  5. rsp_ready held low 10 cycles: rsp fields stable, cmd_ready=0, no AXI activity;
//     new cmd accepted the cycle after rsp handshake.
//  6. Assert i_rstn=0 while awvalid is high and unacked:
//     all outputs 0 immediately; after release a read completes normally.

Source files
------------

// File: rtl/sauria_cfg_axil_master.sv
// AXI4-Lite initiator for the SAURIA configuration port.
// Turns a command stream into single AXI4-Lite reads and writes and returns one response per command.
// Only one transaction is in flight at a time.
// A wait timeout on B/R reports a hung slave, and the block then stays parked until reset.
module sauria_cfg_axil_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned STRB_W     = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    // command / response stream
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic [STRB_W-1:0] i_cmd_wstrb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic [1:0]        o_rsp_resp,
    output logic              o_rsp_timeout,
    output logic              o_busy,
    // AXI4-Lite write address / data / response
    output logic              o_awvalid,
    output logic [ADDR_W-1:0] o_awaddr,
    input  logic              i_awready,
    output logic              o_wvalid,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    input  logic              i_wready,
    input  logic              i_bvalid,
    input  logic [1:0]        i_bresp,
    output logic              o_bready,
    // AXI4-Lite read address / data
    output logic              o_arvalid,
    output logic [ADDR_W-1:0] o_araddr,
    input  logic              i_arready,
    input  logic              i_rvalid,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    output logic              o_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP,
        S_HUNG
    } state_t;

    // The timeout counter only has to reach TIMEOUT_CYC-1; a zero setting disables it.
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam int unsigned CNT_W    = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t              state, state_next;
    logic                init_done;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                aw_pend;
    logic                w_pend;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                tmo_hit;
    logic                cmd_fire;
    logic                aw_done;
    logic                w_done;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_resp_q;
    logic                rsp_timeout_q;

    // cmd_ready stays low until the first clock after reset so nothing is accepted while reset is applied.
    assign cmd_fire = i_cmd_valid && (state == S_IDLE) && init_done;
    // The write address phase is done once each channel has handshaken, now or earlier.
    assign aw_done  = !aw_pend || i_awready;
    assign w_done   = !w_pend  || i_wready;
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_cnt == CNT_W'(TMO_LAST));

    // State register; an asynchronous reset abandons any in-flight command.
    // NOTE: every clocked process uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a response arriving on the expiry cycle takes priority over the timeout.
    // NOTE: state_next is defaulted first so that no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (cmd_fire) state_next = i_cmd_we ? S_WADDR : S_RADDR;
            S_WADDR: if (aw_done && w_done) state_next = S_WRESP;
            S_WRESP: if (i_bvalid || tmo_hit) state_next = S_RSP;
            S_RADDR: if (i_arready) state_next = S_RDATA;
            S_RDATA: if (i_rvalid || tmo_hit) state_next = S_RSP;
            S_RSP:   if (i_rsp_ready) state_next = rsp_timeout_q ? S_HUNG : S_IDLE;
            S_HUNG:  state_next = S_HUNG;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state and datapath registers only, never from slave inputs.
    always_comb begin
        o_cmd_ready   = (state == S_IDLE) && init_done;
        o_busy        = (state != S_IDLE);
        o_awvalid     = aw_pend;
        o_wvalid      = w_pend;
        o_awaddr      = addr_q;
        o_wdata       = wdata_q;
        o_wstrb       = wstrb_q;
        o_bready      = (state == S_WRESP);
        o_arvalid     = (state == S_RADDR);
        o_araddr      = addr_q;
        o_rready      = (state == S_RDATA);
        o_rsp_valid   = (state == S_RSP);
        o_rsp_rdata   = rsp_rdata_q;
        o_rsp_resp    = rsp_resp_q;
        o_rsp_timeout = rsp_timeout_q;
    end

    // Command capture, per-channel handshake tracking, timeout counting and response capture.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            init_done     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_pend       <= 1'b0;
            w_pend        <= 1'b0;
            tmo_cnt       <= '0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            init_done <= 1'b1;

            // The counter runs only while waiting for B or R, so entering either state starts it at 0.
            if ((TIMEOUT_CYC != 0) && ((state == S_WRESP) || (state == S_RDATA))) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            unique case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        addr_q  <= i_cmd_addr;
                        aw_pend <= i_cmd_we;
                        w_pend  <= i_cmd_we;
                        if (i_cmd_we) begin
                            wdata_q <= i_cmd_wdata;
                            wstrb_q <= i_cmd_wstrb;
                        end
                    end
                end
                S_WADDR: begin
                    if (i_awready) aw_pend <= 1'b0;
                    if (i_wready)  w_pend  <= 1'b0;
                end
                S_WRESP: begin
                    if (i_bvalid) begin
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= i_bresp;
                        rsp_timeout_q <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= RESP_SLVERR;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                S_RDATA: begin
                    if (i_rvalid) begin
                        rsp_rdata_q   <= i_rdata;
                        rsp_resp_q    <= i_rresp;
                        rsp_timeout_q <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= RESP_SLVERR;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sauria_cfg_axil_master.sv
// Directed bench for sauria_cfg_axil_master with hand-computed expectations.
// The slave side is driven cycle by cycle from the main sequence; TIMEOUT_CYC is 8.
module tb_sauria_cfg_axil_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [STRB_W-1:0] cmd_wstrb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              busy;
    logic              awvalid, wvalid, bready, arvalid, rready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]        bresp = 2'b00, rresp = 2'b00;
    logic [DATA_W-1:0] rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    sauria_cfg_axil_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(8)
    ) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout), .o_busy(busy),
        .o_awvalid(awvalid), .o_awaddr(awaddr), .i_awready(awready),
        .o_wvalid(wvalid), .o_wdata(wdata), .o_wstrb(wstrb), .i_wready(wready),
        .i_bvalid(bvalid), .i_bresp(bresp), .o_bready(bready),
        .o_arvalid(arvalid), .o_araddr(araddr), .i_arready(arready),
        .i_rvalid(rvalid), .i_rdata(rdata), .i_rresp(rresp), .o_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command in the current cycle and let it be accepted at the next edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        check("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    // Every output that reset forces low, checked together.
    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {cmd_ready, rsp_valid, rsp_timeout, busy, awvalid, wvalid, bready, arvalid, rready}, '0);
        check({tag, "_data"}, {awaddr, wdata}, '0);
        check({tag, "_rsp"}, {rsp_rdata, rsp_resp, wstrb}, '0);
    endtask

    initial begin
        // Reset state, including cmd_ready held low while reset is applied
        #2;
        check_all_zero("reset");
        step();
        rstn = 1'b1;
        check("first_cycle_cmd_ready", cmd_ready, 1'b0);
        step();
        check("post_reset_cmd_ready", cmd_ready, 1'b1);
        check("post_reset_busy", busy, 1'b0);

        // 1: zero-wait write, AW/W at N+1, bready at N+2, rsp at N+3
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        check("t1_aw_w_valid", {awvalid, wvalid, busy, cmd_ready}, 4'b1110);
        check("t1_awaddr", awaddr, 32'h0000_0010);
        check("t1_wdata_strb", {wdata, wstrb}, {32'hDEAD_BEEF, 4'hF});
        step();
        check("t1_bready", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        check("t1_rsp", {rsp_valid, bready, rsp_timeout}, 3'b100);
        check("t1_rsp_fields", {rsp_rdata, rsp_resp}, {32'h0, 2'b00});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t1_back_idle", {rsp_valid, cmd_ready, busy}, 3'b010);

        // 2: W accepted in its first cycle, AW only in its third
        awready = 1'b0; wready = 1'b0;
        issue(1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'h3);
        check("t2_c1_valids", {awvalid, wvalid}, 2'b11);
        wready = 1'b1;
        step();
        wready = 1'b0;
        check("t2_c2_valids", {awvalid, wvalid, bready}, 3'b100);
        check("t2_c2_awaddr", awaddr, 32'h0000_0020);
        step();
        check("t2_c3_valids", {awvalid, wvalid, bready}, 3'b100);
        check("t2_c3_awaddr", awaddr, 32'h0000_0020);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check("t2_wresp", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
        bvalid = 1'b1; bresp = 2'b01;
        step();
        bvalid = 1'b0;
        check("t2_rsp", {rsp_valid, rsp_resp, rsp_timeout, bready}, 5'b1_01_0_0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t2_single_rsp", {rsp_valid, cmd_ready}, 2'b01);

        // 3: read, slave answers 5 cycles into the data phase with SLVERR
        arready = 1'b1;
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        check("t3_arvalid", {arvalid, awvalid, wvalid}, 3'b100);
        check("t3_araddr", araddr, 32'h0000_0004);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_rdata_wait", {rready, arvalid, rsp_valid}, 3'b100);
            step();
        end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        step();
        rvalid = 1'b0;
        check("t3_rsp", {rsp_valid, rsp_resp, rsp_timeout, rready}, 5'b1_10_0_0);
        check("t3_rsp_rdata", rsp_rdata, 32'h1234_5678);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 5: response stalled 10 cycles while a new command waits; accepted the cycle after handshake
        issue(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h8);
        awready = 1'b1; wready = 1'b1;
        step();
        bvalid = 1'b1; bresp = 2'b11;
        step();
        bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0040;
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_rsp", {rsp_valid, rsp_resp, rsp_timeout, rsp_rdata}, {1'b1, 2'b11, 1'b0, 32'h0});
            check("t5_hold_quiet", {cmd_ready, awvalid, wvalid, bready, arvalid, rready}, 6'b0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t5_ready_after_hs", {cmd_ready, rsp_valid, arvalid}, 3'b100);
        step();
        cmd_valid = 1'b0;
        check("t5_next_cmd_arvalid", {arvalid, cmd_ready}, 2'b10);
        check("t5_next_cmd_araddr", araddr, 32'h0000_0040);
        step();
        rvalid = 1'b1; rdata = 32'hA5A5_0F0F; rresp = 2'b00;
        step();
        rvalid = 1'b0;
        check("t5_read_rsp", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'hA5A5_0F0F});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Boundary: R arrives on the last timeout cycle, the normal response wins
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 7; i++) step();
        check("edge_no_rsp_yet", {rsp_valid, rready}, 2'b01);
        rvalid = 1'b1; rdata = 32'h0000_00EE; rresp = 2'b00;
        step();
        rvalid = 1'b0;
        check("edge_normal_wins", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1_0_00);
        check("edge_rdata", rsp_rdata, 32'h0000_00EE);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 4: slave never answers, timeout 8 cycles into the data phase, then HUNG
        issue(1'b0, 32'h0000_000C, 32'h0, 4'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            check("t4_waiting", {rsp_valid, rready}, 2'b01);
            step();
        end
        check("t4_timeout_rsp", {rsp_valid, rsp_timeout, rsp_resp, rready}, 5'b1_1_10_0);
        check("t4_timeout_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        cmd_valid = 1'b1; cmd_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_hung", {cmd_ready, busy, rsp_valid, rready, arvalid, awvalid, bready}, 7'b0100000);
            step();
        end
        rvalid = 1'b0; cmd_valid = 1'b0;

        // Reset leaves HUNG
        rstn = 1'b0;
        #1;
        check_all_zero("hung_reset");
        step();
        rstn = 1'b1;
        step();
        check("hung_cleared", {cmd_ready, busy}, 2'b10);

        // 6: reset asserted while AW is outstanding, then a normal read
        awready = 1'b0; wready = 1'b0;
        issue(1'b1, 32'h0000_0050, 32'h1111_2222, 4'hF);
        check("t6_aw_pending", {awvalid, wvalid}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("t6_async");
        step();
        rstn = 1'b1;
        step();
        arready = 1'b1;
        issue(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        check("t6_read_ar", {arvalid, araddr}, {1'b1, 32'h0000_0060});
        step();
        rvalid = 1'b1; rdata = 32'h5555_AAAA; rresp = 2'b00;
        step();
        rvalid = 1'b0;
        check("t6_read_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h5555_AAAA});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t6_idle", {cmd_ready, busy}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
